// File: rtl/nim_turn_controller.sv
// Nim game sequencer: conditions the raw buttons, arbitrates one event per
// cycle and owns the piles, the turn, the row lock and win detection.
module nim_turn_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned PILE1_INIT      = 1,
  parameter int unsigned PILE2_INIT      = 3,
  parameter int unsigned PILE3_INIT      = 5,
  parameter int unsigned PILE4_INIT      = 7,
  parameter int unsigned MISERE          = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic [3:0] take_btn,
  input  logic       pass_btn,
  output logic [2:0] pile1,
  output logic [2:0] pile2,
  output logic [2:0] pile3,
  output logic [2:0] pile4,
  output logic [3:0] locked_row,
  output logic       player,
  output logic [2:0] take_count,
  output logic       game_over,
  output logic       winner,
  output logic [1:0] fsm_state
);

  localparam int unsigned NumBtn = 5;  // take_btn[3:0] plus pass_btn
  localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [1:0] TURN_START = 2'b00;
  localparam logic [1:0] TAKING     = 2'b01;
  localparam logic [1:0] GAME_OVER  = 2'b10;

  localparam logic [3:0][2:0] PileInit = {3'(PILE4_INIT), 3'(PILE3_INIT),
                                          3'(PILE2_INIT), 3'(PILE1_INIT)};

  // Piles are 3 bits wide; larger initial counts would silently truncate.
  if (PILE1_INIT > 7 || PILE2_INIT > 7 || PILE3_INIT > 7 || PILE4_INIT > 7) begin : gen_bad_init
    $error("nim_turn_controller: PILE*_INIT must be in 0..7");
  end

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [NumBtn-1:0]           raw_btn;
  logic [NumBtn-1:0]           sync1_q, sync2_q;
  logic [NumBtn-1:0]           level_q, level_d;
  logic [NumBtn-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [NumBtn-1:0]           pulse_q, pulse_d;

  assign raw_btn = {pass_btn, take_btn};

  // Two-flop synchronizer for every raw button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_btn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = '0;
    for (int i = 0; i < NumBtn; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
        if (cnt_d[i] == CntW'(DEBOUNCE_CYCLES)) begin
          level_d[i] = ~level_q[i];
          cnt_d[i]   = '0;
        end
      end
      pulse_d[i] = level_d[i] & ~level_q[i];
    end
    if (new_game) begin
      level_d = '0;
      cnt_d   = '0;
      pulse_d = '0;
    end
  end

  // Debounce state and the registered one-cycle rising-edge pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      cnt_q   <= '0;
      pulse_q <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Event arbitration: row4 > row3 > row2 > row1 > pass; losers are dropped.
  // ---------------------------------------------------------------------------
  logic [3:0] take_sel;
  logic       pass_ev;

  // Pick the single highest-priority pulse of this cycle.
  always_comb begin
    take_sel = 4'b0000;
    pass_ev  = 1'b0;
    if (pulse_q[3])      take_sel = 4'b1000;
    else if (pulse_q[2]) take_sel = 4'b0100;
    else if (pulse_q[1]) take_sel = 4'b0010;
    else if (pulse_q[0]) take_sel = 4'b0001;
    else                 pass_ev  = pulse_q[4];
  end

  // ---------------------------------------------------------------------------
  // Game state
  // ---------------------------------------------------------------------------
  logic [3:0][2:0] pile_q, pile_d;
  logic [3:0]      locked_q, locked_d;
  logic            player_q, player_d;
  logic [2:0]      take_q, take_d;
  logic            over_q, over_d;
  logic            winner_q, winner_d;
  logic [1:0]      state_q, state_d;
  logic            took;

  // Turn rules; game-over detection rides on the same edge as a decrement.
  always_comb begin
    pile_d   = pile_q;
    locked_d = locked_q;
    player_d = player_q;
    take_d   = take_q;
    over_d   = over_q;
    winner_d = winner_q;
    state_d  = state_q;
    took     = 1'b0;
    case (state_q)
      TURN_START: begin
        for (int r = 0; r < 4; r++) begin
          if (take_sel[r] && pile_q[r] != 3'd0) begin
            pile_d[r] = pile_q[r] - 3'd1;
            locked_d  = take_sel;
            take_d    = 3'd1;
            state_d   = TAKING;
            took      = 1'b1;
          end
        end
      end
      TAKING: begin
        for (int r = 0; r < 4; r++) begin
          if (take_sel[r] && locked_q[r] && pile_q[r] != 3'd0) begin
            pile_d[r] = pile_q[r] - 3'd1;
            take_d    = take_q + 3'd1;
            took      = 1'b1;
          end
        end
        if (pass_ev) begin
          player_d = ~player_q;
          locked_d = 4'b0000;
          take_d   = 3'd0;
          state_d  = TURN_START;
        end
      end
      GAME_OVER: ;
      default: state_d = TURN_START;
    endcase
    if (took && pile_d == '0) begin
      state_d  = GAME_OVER;
      over_d   = 1'b1;
      winner_d = player_q ^ 1'(MISERE);
      locked_d = 4'b0000;
    end
    if (new_game) begin
      pile_d   = PileInit;
      locked_d = 4'b0000;
      player_d = 1'b0;
      take_d   = 3'd0;
      over_d   = 1'b0;
      winner_d = 1'b0;
      state_d  = TURN_START;
    end
  end

  // Game state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pile_q   <= PileInit;
      locked_q <= 4'b0000;
      player_q <= 1'b0;
      take_q   <= 3'd0;
      over_q   <= 1'b0;
      winner_q <= 1'b0;
      state_q  <= TURN_START;
    end else begin
      pile_q   <= pile_d;
      locked_q <= locked_d;
      player_q <= player_d;
      take_q   <= take_d;
      over_q   <= over_d;
      winner_q <= winner_d;
      state_q  <= state_d;
    end
  end

  assign pile1      = pile_q[0];
  assign pile2      = pile_q[1];
  assign pile3      = pile_q[2];
  assign pile4      = pile_q[3];
  assign locked_row = locked_q;
  assign player     = player_q;
  assign take_count = take_q;
  assign game_over  = over_q;
  assign winner     = winner_q;
  assign fsm_state  = state_q;

endmodule
